// File: rtl/miner_csr_slave.sv
// rtl/miner_csr_slave.sv - Avalon-MM CSR slave for the miner: header config, start/irq control, per-core found/done/nonce status
module miner_csr_slave #(
  parameter int SLAVE_ADDRESSWIDTH = 5,
  parameter int DATAWIDTH          = 32,
  parameter int NUM_CORES          = 4,
  parameter int NUM_CFG_REGS       = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]     slave_address,
  input  logic [DATAWIDTH-1:0]              slave_writedata,
  input  logic                              slave_write,
  input  logic                              slave_read,
  input  logic                              slave_chipselect,
  output logic [DATAWIDTH-1:0]              slave_readdata,
  input  logic [NUM_CORES-1:0]              core_found,
  input  logic [NUM_CORES-1:0]              core_done,
  input  logic [NUM_CORES*DATAWIDTH-1:0]    core_nonce,
  output logic [NUM_CFG_REGS*DATAWIDTH-1:0] cfg_regs,
  output logic                              start,
  output logic                              busy,
  output logic                              irq
);

  localparam int CFG_BASE   = 3;
  localparam int NONCE_BASE = CFG_BASE + NUM_CFG_REGS;

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_CTRL  = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_FOUND = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_DONE  = SLAVE_ADDRESSWIDTH'(2);

  logic                 wr_en;
  logic                 rd_en;
  logic                 ctrl_wr;
  logic                 clear_req;
  logic                 start_req;
  logic [NUM_CORES-1:0] found_w1c;
  logic [NUM_CORES-1:0] done_w1c;
  logic [NUM_CORES-1:0] capture;
  logic [NUM_CORES-1:0] found_d;
  logic [NUM_CORES-1:0] done_d;
  logic [NUM_CORES-1:0] found_q;
  logic [NUM_CORES-1:0] done_q;
  logic [DATAWIDTH-1:0] nonce_q [NUM_CORES];
  logic [DATAWIDTH-1:0] cfg_q   [NUM_CFG_REGS];
  logic                 irq_en_q;
  logic                 busy_q;
  logic                 start_q;
  logic                 irq_q;
  logic [DATAWIDTH-1:0] rdata_d;
  logic [DATAWIDTH-1:0] rdata_q;

  // A simultaneous read+write performs only the write; readdata holds.
  assign wr_en = slave_chipselect & slave_write;
  assign rd_en = slave_chipselect & slave_read & ~slave_write;

  assign ctrl_wr   = wr_en && (slave_address == ADDR_CTRL);
  assign clear_req = ctrl_wr & slave_writedata[2];
  // CLEAR together with START restarts even while a search is running.
  assign start_req = ctrl_wr & slave_writedata[0] & (~busy_q | slave_writedata[2]);

  assign found_w1c = (wr_en && (slave_address == ADDR_FOUND)) ? slave_writedata[NUM_CORES-1:0] : '0;
  assign done_w1c  = (wr_en && (slave_address == ADDR_DONE))  ? slave_writedata[NUM_CORES-1:0] : '0;

  // First nonce wins; a bit being W1C'd this cycle counts as free again.
  assign capture = core_found & (~found_q | found_w1c);
  assign found_d = core_found | (found_q & ~found_w1c);
  assign done_d  = core_done  | (done_q  & ~done_w1c);

  always_ff @(posedge clk) begin
    if (reset) begin
      found_q  <= '0;
      done_q   <= '0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_q[i] <= '0;
      end
      for (int k = 0; k < NUM_CFG_REGS; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      start_q <= start_req;
      if (ctrl_wr) begin
        irq_en_q <= slave_writedata[1];
      end

      if (start_req) begin
        busy_q <= 1'b1;
      end else if (clear_req || (&done_q)) begin
        busy_q <= 1'b0;
      end

      irq_q <= irq_en_q & ((|found_q) | (&done_q));

      if (clear_req) begin
        found_q <= '0;
        done_q  <= '0;
      end else begin
        found_q <= found_d;
        done_q  <= done_d;
      end

      for (int i = 0; i < NUM_CORES; i++) begin
        if (clear_req) begin
          nonce_q[i] <= '0;
        end else if (capture[i]) begin
          nonce_q[i] <= core_nonce[i*DATAWIDTH +: DATAWIDTH];
        end
      end

      for (int k = 0; k < NUM_CFG_REGS; k++) begin
        if (wr_en && (slave_address == SLAVE_ADDRESSWIDTH'(CFG_BASE + k))) begin
          cfg_q[k] <= slave_writedata;
        end
      end

      if (rd_en) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (slave_address == ADDR_CTRL) begin
      rdata_d[DATAWIDTH-1] = busy_q;
      rdata_d[1]           = irq_en_q;
    end else if (slave_address == ADDR_FOUND) begin
      rdata_d[NUM_CORES-1:0] = found_q;
    end else if (slave_address == ADDR_DONE) begin
      rdata_d[NUM_CORES-1:0] = done_q;
    end
    for (int k = 0; k < NUM_CFG_REGS; k++) begin
      if (slave_address == SLAVE_ADDRESSWIDTH'(CFG_BASE + k)) begin
        rdata_d = cfg_q[k];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (slave_address == SLAVE_ADDRESSWIDTH'(NONCE_BASE + i)) begin
        rdata_d = nonce_q[i];
      end
    end
  end

  for (genvar k = 0; k < NUM_CFG_REGS; k++) begin : g_cfg_out
    assign cfg_regs[k*DATAWIDTH +: DATAWIDTH] = cfg_q[k];
  end

  assign slave_readdata = rdata_q;
  assign start          = start_q;
  assign busy           = busy_q;
  assign irq            = irq_q;

endmodule
